// File: rtl/mining_engine_if.sv
// Bus between the UART byte assembler / transmitter and the mining engine.
// master: UART side (drives handshakes and header); slave: the engine.
interface mining_engine_if;
  logic         finished_recieving;
  logic         finished_sending;
  logic [607:0] block_without_nonce;
  logic         read_enable;
  logic         hash_enable;
  logic         write_enable;
  logic         second_tick;
  logic [255:0] best_hash;
  logic [31:0]  best_hash_nonce;

  modport master (
    output finished_recieving, finished_sending, block_without_nonce,
    input  read_enable, hash_enable, write_enable, second_tick, best_hash, best_hash_nonce
  );

  modport slave (
    input  finished_recieving, finished_sending, block_without_nonce,
    output read_enable, hash_enable, write_enable, second_tick, best_hash, best_hash_nonce
  );
endinterface

// File: rtl/mining_engine.sv
// Mining engine: read/hash/write phase FSM, hashing-period timer and an iterative
// double-SHA-256 nonce search. Define MIDSTATE_EN to cache the nonce-independent first block.
module mining_engine #(
  parameter int unsigned CLK_RATE = 100_000_000
) (
  input logic            clk,
  input logic            rst_i,
  mining_engine_if.slave bus
);
  // state   | meaning
  // S_READ  | waiting for the header bytes from the UART receiver
  // S_HASH  | nonce search running, hashing timer counting
  // S_WRITE | best nonce being serialised by the UART transmitter
  // C_RND   | one SHA-256 round
  // C_FIN   | fold working vars into chaining value, load next block
  // C_CMP   | compare digest against best, advance nonce
  typedef enum logic [2:0] {S_READ = 3'b001, S_HASH = 3'b010, S_WRITE = 3'b100} phase_t;
  typedef enum logic [1:0] {C_RND, C_FIN, C_CMP} core_t;

  localparam logic [31:0] TC = 32'(CLK_RATE - 1);

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sml_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Header byte i lives at [8i+7:8i]; SHA-256 words are big-endian byte groups.
  function automatic logic [31:0] hdr_word(input logic [607:0] hdr, input int i);
    return {hdr[32*i +: 8], hdr[32*i+8 +: 8], hdr[32*i+16 +: 8], hdr[32*i+24 +: 8]};
  endfunction

  function automatic logic [15:0][31:0] blk1_words(input logic [607:0] hdr);
    logic [15:0][31:0] m;
    for (int i = 0; i < 16; i++) m[i] = hdr_word(hdr, i);
    return m;
  endfunction

  // Bytes 64..75 of the header, little-endian nonce, then padding for a 640-bit message.
  function automatic logic [15:0][31:0] blk2_words(input logic [607:0] hdr, input logic [31:0] n);
    logic [15:0][31:0] m;
    m = '0;
    for (int i = 0; i < 3; i++) m[i] = hdr_word(hdr, 16 + i);
    m[3]  = {n[7:0], n[15:8], n[23:16], n[31:24]};
    m[4]  = 32'h8000_0000;
    m[15] = 32'h0000_0280;
    return m;
  endfunction

  function automatic logic [15:0][31:0] blk3_words(input logic [7:0][31:0] d);
    logic [15:0][31:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i] = d[i];
    m[8]  = 32'h8000_0000;
    m[15] = 32'h0000_0100;
    return m;
  endfunction

  // Digest byte j (FIPS output order) lands at [8j+7:8j].
  function automatic logic [255:0] to_le(input logic [7:0][31:0] h);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 4; b++) r[32*i + 8*b +: 8] = h[i][31 - 8*b -: 8];
    return r;
  endfunction

  phase_t            state, state_nx;
  core_t             core_st, core_nx;
  logic              hash_enable, hash_start, second_tick;
  logic [31:0]       count;
  logic [31:0]       nonce;
  logic [255:0]      best_hash, dig_le;
  logic [31:0]       best_hash_nonce;
  logic [7:0][31:0]  v, v_rnd, hs, sum;
  logic [15:0][31:0] w, w_nx;
  logic [31:0]       t1, t2;
  logic [5:0]        rnd;
  logic [1:0]        blk;
`ifdef MIDSTATE_EN
  logic [7:0][31:0]  mid;
`endif

  assign hash_enable = (state == S_HASH);
  assign hash_start  = (state == S_READ) && bus.finished_recieving;
  assign second_tick = hash_enable && (count == TC);

  assign bus.read_enable     = (state == S_READ);
  assign bus.hash_enable     = hash_enable;
  assign bus.write_enable    = (state == S_WRITE);
  assign bus.second_tick     = second_tick;
  assign bus.best_hash       = best_hash;
  assign bus.best_hash_nonce = best_hash_nonce;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) state <= S_READ;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_READ:  if (bus.finished_recieving) state_nx = S_HASH;
      S_HASH:  if (second_tick)            state_nx = S_WRITE;
      S_WRITE: if (bus.finished_sending)   state_nx = S_READ;
      default: state_nx = S_READ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i)            count <= '0;
    else if (!hash_enable) count <= '0;
    else if (count == TC)  count <= '0;
    else                   count <= count + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i)           core_st <= C_RND;
    else if (hash_start)  core_st <= C_RND;
    else if (hash_enable) core_st <= core_nx;
  end

  always_comb begin
    core_nx = core_st;
    unique case (core_st)
      C_RND:   if (rnd == 6'd63) core_nx = C_FIN;
      C_FIN:   core_nx = (blk == 2'd2) ? C_CMP : C_RND;
      C_CMP:   core_nx = C_RND;
      default: core_nx = C_RND;
    endcase
  end

  always_comb begin
    t1 = v[7] + big_s1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[rnd] + w[0];
    t2 = big_s0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    v_rnd    = v;
    v_rnd[0] = t1 + t2;
    v_rnd[1] = v[0];
    v_rnd[2] = v[1];
    v_rnd[3] = v[2];
    v_rnd[4] = v[3] + t1;
    v_rnd[5] = v[4];
    v_rnd[6] = v[5];
    v_rnd[7] = v[6];
  end

  // Rolling 16-word schedule window: w[0] is the word for the current round.
  always_comb begin
    w_nx = w;
    for (int i = 0; i < 15; i++) w_nx[i] = w[i+1];
    w_nx[15] = sml_s1(w[14]) + w[9] + sml_s0(w[1]) + w[0];
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++) sum[i] = hs[i] + v[i];
  end

  assign dig_le = to_le(hs);

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      nonce           <= '0;
      best_hash       <= '1;
      best_hash_nonce <= '0;
      v               <= '0;
      hs              <= '0;
      w               <= '0;
      rnd             <= '0;
      blk             <= '0;
`ifdef MIDSTATE_EN
      mid             <= '0;
`endif
    end else if (hash_start) begin
      nonce           <= '0;
      best_hash       <= '1;
      best_hash_nonce <= '0;
      v               <= IV;
      hs              <= IV;
      w               <= blk1_words(bus.block_without_nonce);
      rnd             <= '0;
      blk             <= '0;
    end else if (hash_enable) begin
      unique case (core_st)
        C_RND: begin
          v   <= v_rnd;
          w   <= w_nx;
          rnd <= rnd + 6'd1;
        end
        C_FIN: begin
          unique case (blk)
            2'd0: begin
              hs  <= sum;
              v   <= sum;
              w   <= blk2_words(bus.block_without_nonce, nonce);
              blk <= 2'd1;
`ifdef MIDSTATE_EN
              mid <= sum;
`endif
            end
            2'd1: begin
              hs  <= IV;
              v   <= IV;
              w   <= blk3_words(sum);
              blk <= 2'd2;
            end
            default: hs <= sum;
          endcase
        end
        C_CMP: begin
          if (dig_le < best_hash) begin
            best_hash       <= dig_le;
            best_hash_nonce <= nonce;
          end
          nonce <= nonce + 32'd1;
`ifdef MIDSTATE_EN
          hs  <= mid;
          v   <= mid;
          w   <= blk2_words(bus.block_without_nonce, nonce + 32'd1);
          blk <= 2'd1;
`else
          hs  <= IV;
          v   <= IV;
          w   <= blk1_words(bus.block_without_nonce);
          blk <= 2'd0;
`endif
        end
        default: blk <= 2'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_mining_engine.sv
// Self-checking bench for mining_engine: phase sequencing table, SHA256d search
// against a software model, genesis-block digest, hold/restart and async reset.
module tb_mining_engine;
  localparam int unsigned RATE = 1000;
  localparam logic [255:0] M_IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] GEN_EXP = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

  localparam logic [31:0] KM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    logic       fr;
    logic       fs;
    int         n;
    logic [3:0] exp;   // {read, hash, write, tick}
  } step_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   tick_cnt = 0;

  mining_engine_if bus();

  mining_engine #(.CLK_RATE(RATE)) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.second_tick) tick_cnt++;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] m_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KM[t] + w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Double SHA-256 of header||LE nonce, returned with digest byte j at [8j+7:8j].
  function automatic logic [255:0] m_sha256d(input logic [607:0] hdr, input logic [31:0] n);
    logic [639:0]  msg;
    logic [1023:0] p1;
    logic [511:0]  p2;
    logic [255:0]  st, d1, d2, le;
    for (int i = 0; i < 76; i++) msg[639 - 8*i -: 8] = hdr[8*i +: 8];
    msg[31:0] = {n[7:0], n[15:8], n[23:16], n[31:24]};
    p1 = {msg, 8'h80, 312'd0, 64'd640};
    st = m_compress(M_IV, p1[1023:512]);
    d1 = m_compress(st, p1[511:0]);
    p2 = {d1, 8'h80, 184'd0, 64'd256};
    d2 = m_compress(M_IV, p2);
    for (int j = 0; j < 32; j++) le[8*j +: 8] = d2[255 - 8*j -: 8];
    return le;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step_t        steps [9];
    logic [607:0] gen_be;
    logic [607:0] hdr;
    logic [255:0] m_best, d;
    logic [31:0]  m_best_nonce;

    gen_be = 608'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a_29ab5f49_ffff001d;
    for (int i = 0; i < 76; i++) hdr[8*i +: 8] = gen_be[607 - 8*i -: 8];

    chk("model_genesis", m_sha256d(hdr, 32'h7C2BAC1D), GEN_EXP);
    m_best = '1;
    m_best_nonce = '0;
    for (int n = 0; n < 5; n++) begin
      d = m_sha256d(hdr, 32'(n));
      if (d < m_best) begin
        m_best = d;
        m_best_nonce = 32'(n);
      end
    end

    steps[0] = '{1'b0, 1'b1, 2,   4'b1000};  // finished_sending ignored in READ
    steps[1] = '{1'b1, 1'b0, 1,   4'b0100};  // enter HASH, cycle 0
    steps[2] = '{1'b1, 1'b0, 4,   4'b0100};  // finished_recieving ignored in HASH
    steps[3] = '{1'b0, 1'b1, 10,  4'b0100};  // finished_sending ignored in HASH
    steps[4] = '{1'b0, 1'b0, 985, 4'b0101};  // cycle 999: tick
    steps[5] = '{1'b1, 1'b0, 1,   4'b0010};  // cycle 1000: WRITE
    steps[6] = '{1'b1, 1'b0, 3,   4'b0010};  // finished_recieving ignored in WRITE
    steps[7] = '{1'b0, 1'b1, 1,   4'b1000};  // back to READ
    steps[8] = '{1'b0, 1'b0, 5,   4'b1000};

    bus.finished_recieving  = 1'b0;
    bus.finished_sending    = 1'b0;
    bus.block_without_nonce = hdr;

    #1 rst_i = 1'b0;
    #1;
    chk("reset_enables", {bus.read_enable, bus.hash_enable, bus.write_enable, bus.second_tick}, 4'b1000);
    chk("reset_best_hash", bus.best_hash, {256{1'b1}});
    chk("reset_best_nonce", bus.best_hash_nonce, 32'd0);
    cyc(2);
    rst_i = 1'b1;
    chk("reset_release", {bus.read_enable, bus.hash_enable, bus.write_enable}, 3'b100);

    for (int i = 0; i < 9; i++) begin
      bus.finished_recieving = steps[i].fr;
      bus.finished_sending   = steps[i].fs;
      cyc(steps[i].n);
      chk($sformatf("phase_step%0d", i),
          {bus.read_enable, bus.hash_enable, bus.write_enable, bus.second_tick}, steps[i].exp);
      if (i == 5) begin
        chk("search_best_hash", bus.best_hash, m_best);
        chk("search_best_nonce", bus.best_hash_nonce, m_best_nonce);
        chk("search_nonce_count", dut.nonce, 32'd5);
      end
    end

    chk("tick_count", tick_cnt, 1);
    chk("hold_best_hash", bus.best_hash, m_best);
    chk("hold_best_nonce", bus.best_hash_nonce, m_best_nonce);

    bus.finished_recieving = 1'b1;
    cyc(1);
    bus.finished_recieving = 1'b0;
    chk("restart_hash_enable", bus.hash_enable, 1'b1);
    chk("restart_best_hash", bus.best_hash, {256{1'b1}});
    chk("restart_best_nonce", bus.best_hash_nonce, 32'd0);

    force dut.nonce = 32'h7C2BAC1D;
    cyc(195);
    chk("genesis_before_compare", bus.best_hash, {256{1'b1}});
    cyc(1);
    chk("genesis_best_hash", bus.best_hash, GEN_EXP);
    chk("genesis_best_nonce", bus.best_hash_nonce, 32'h7C2BAC1D);
    release dut.nonce;

    cyc(3);
    #1 rst_i = 1'b0;
    #1;
    chk("async_reset_enables", {bus.read_enable, bus.hash_enable, bus.write_enable, bus.second_tick}, 4'b1000);
    chk("async_reset_best_hash", bus.best_hash, {256{1'b1}});
    chk("async_reset_best_nonce", bus.best_hash_nonce, 32'd0);
    cyc(2);
    rst_i = 1'b1;
    cyc(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
